encoder: RTL and testbench

- Rate-1/2 feed-forward binary convolutional encoder; one input bit in, two coded bits out, every clock.
- Default code: constraint length K=3, generators G0=7 (octal, 111b) and G1=5 (octal, 101b).
- Sits between the bit source and the modulator/interleaver in the transmit chain.
- Output is registered. Input is accepted on every rising clock edge; there is no handshake.

---
 rtl/enc_pkg.sv | 27 ++
 rtl/encoder_conv_branch.sv | 29 ++
 rtl/encoder.sv | 81 ++++++++
 tb/tb_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Package : enc_pkg
//  Shared defaults, types and the parity helper for the rate-1/2
//  convolutional encoder.
//  Revision: 1.0 - initial release
// ============================================================================
package enc_pkg;

  // Default code: K=3, generators 7 and 5 (octal)
  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // Widest window any legal constraint length can produce
  localparam int K_MAX = 9;

  typedef logic [1:0] code_pair_t;

  // XOR-reduction of the tapped window bits; narrower windows are zero-extended
  function automatic logic parity(input logic [K_MAX-1:0] window,
                                  input logic [K_MAX-1:0] poly);
    return ^(window & poly);
  endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/encoder_conv_branch.sv
`default_nettype none
// ============================================================================
//  Module  : conv_branch
//  One generator branch of the convolutional encoder: parity of the current
//  window masked by the branch polynomial. Purely combinational.
//  Revision: 1.0 - initial release
// ============================================================================
module conv_branch
  import enc_pkg::*;
#(
  parameter int           K    = K_DEF,
  parameter logic [K-1:0] POLY = K'(G0_DEF)
) (
  input  logic [K-1:0] window,
  output logic         branch_bit
);

  localparam logic [K_MAX-1:0] c_poly_ext = K_MAX'(POLY);

  logic [K_MAX-1:0] w_window_ext;

  // Zero-extend so the shared helper sees a fixed-width window
  always_comb begin
    w_window_ext = K_MAX'(window);
    branch_bit   = parity(w_window_ext, c_poly_ext);
  end

endmodule : conv_branch
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
//  Module  : encoder
//  Rate-1/2 feed-forward binary convolutional encoder. One bit in, one
//  registered code pair out on every rising clock edge; no handshake.
//  data_out[1] is the G0 branch, data_out[0] the G1 branch.
//  Revision: 1.0 - initial release
// ============================================================================
module encoder
  import enc_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = K'(G0_DEF),
  parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
  input  logic       clk,
  input  logic       reset,     // synchronous, active low
  input  logic       data_in,
  output logic [1:0] data_out
);

  // Reject illegal configurations while elaborating
  if (K < 2 || K > K_MAX) begin : g_bad_k
    $error("encoder: K=%0d outside legal range 2..%0d", K, K_MAX);
  end
  if (G0 == '0) begin : g_bad_g0
    $error("encoder: G0 must be non-zero");
  end
  if (G1 == '0) begin : g_bad_g1
    $error("encoder: G1 must be non-zero");
  end

  // Past input bits; r_sr[K-2] is the most recent, r_sr[0] the oldest
  logic [K-2:0] r_sr;
  code_pair_t   r_out;

  logic [K-1:0] w_window;
  logic [K-2:0] w_sr_next;
  logic         w_bit_g0;
  logic         w_bit_g1;

  assign w_window = {data_in, r_sr};

  // New bit enters at the MSB; with a single stored bit there is nothing to shift
  if (K == 2) begin : g_sr_single
    assign w_sr_next = data_in;
  end else begin : g_sr_shift
    assign w_sr_next = {data_in, r_sr[K-2:1]};
  end

  conv_branch #(
    .K    (K),
    .POLY (G0)
  ) u_branch_g0 (
    .window     (w_window),
    .branch_bit (w_bit_g0)
  );

  conv_branch #(
    .K    (K),
    .POLY (G1)
  ) u_branch_g1 (
    .window     (w_window),
    .branch_bit (w_bit_g1)
  );

  // Advance the trellis state and register the code pair; reset discards history
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr  <= '0;
      r_out <= '0;
    end else begin
      r_sr  <= w_sr_next;
      r_out <= {w_bit_g0, w_bit_g1};
    end
  end

  assign data_out = r_out;

endmodule : encoder
`default_nettype wire

// File: tb/tb_encoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_encoder
//  Self-checking bench for encoder: the default K=3 (7,5) code and a K=4
//  (17,13) override run side by side on the same stimulus, each against a
//  history-based reference model, plus literal expected sequences.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_encoder;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [1:0] out3;
  logic [1:0] out4;

  int n_checks;
  int n_errors;

  // Reference history: bit 0 is the most recent past input
  logic [15:0] hist;

  encoder u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (out3)
  );

  encoder #(
    .K  (4),
    .G0 (4'b1111),
    .G1 (4'b1011)
  ) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Code pair from the convolution definition: input x[j] (x[0] current,
  // x[j] the bit j steps back) is tapped by generator bit K-1-j
  function automatic logic [1:0] model(input int k, input logic [8:0] g0,
                                       input logic [8:0] g1, input logic din,
                                       input logic [15:0] h);
    logic a0, a1, x;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int j = 0; j < k; j++) begin
      x  = (j == 0) ? din : h[j-1];
      a0 = a0 ^ (g0[k-1-j] & x);
      a1 = a1 ^ (g1[k-1-j] & x);
    end
    return {a0, a1};
  endfunction

  // One clock: drive, let the edge happen, sample 1 time unit later, compare both DUTs
  task automatic step(input logic rst_n, input logic din);
    logic [1:0] e3, e4;
    reset   = rst_n;
    data_in = din;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e3   = 2'b00;
      e4   = 2'b00;
      hist = '0;
    end else begin
      e3   = model(3, 9'b111,  9'b101,  din, hist);
      e4   = model(4, 9'b1111, 9'b1011, din, hist);
      hist = {hist[14:0], din};
    end
    check("model_k3", out3, e3);
    check("model_k4", out4, e4);
  endtask

  initial begin
    logic [6:0] seq_in;
    logic [1:0] seq_out [7];
    logic [1:0] imp3 [6];
    logic [1:0] imp4 [6];
    logic       r, d;

    n_checks = 0;
    n_errors = 0;
    hist     = '0;
    reset    = 1'b0;
    data_in  = 1'b0;

    // Reset state
    step(1'b0, 1'b0);
    check("reset_k3", out3, 2'b00);
    check("reset_k4", out4, 2'b00);

    // Reference sequence 1,1,0,1,0,0,0
    seq_in  = 7'b1101000;
    seq_out = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq_in[6-i]);
      check("seq_a", out3, seq_out[i]);
    end

    // Reset held 3 cycles while data toggles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i % 2 == 0));
      check("hold_rst", out3, 2'b00);
    end
    step(1'b1, 1'b0);
    check("post_rst_zero", out3, 2'b00);

    // Mid-stream reset drops the 1,1 history
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("mid_rst", out3, 2'b00);
    step(1'b1, 1'b0);
    check("mid_rst_0", out3, 2'b00);
    step(1'b1, 1'b1);
    check("mid_rst_1", out3, 2'b11);

    // Impulse response for both codes
    step(1'b0, 1'b0);
    imp3 = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    imp4 = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'(i == 0));
      check("impulse_k3", out3, imp3[i]);
      check("impulse_k4", out4, imp4[i]);
    end

    // All-ones stream
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("all_ones", out3, (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : 2'b10);
    end

    // Zero tail terminates the trellis
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("tail_k3", out3, 2'b00);

    // Random stream with occasional resets
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) != 0);
      d = 1'($urandom);
      step(r, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_encoder
`default_nettype wire
